// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and constants for the DRAM request arbiter.
//   dram_arb_state_e : arbiter FSM state encoding.
//   DEF_N_REQ / DEF_MAX_BURST : default configuration, with TAG_W and CNT_W derived from it.
//   ptr_w()          : index width for a table of the given depth (never below 1).
package dram_arb_pkg;

  typedef enum logic [1:0] {
    StWaitCal = 2'd0,
    StIdle    = 2'd1,
    StBurst   = 2'd2
  } dram_arb_state_e;

  localparam int unsigned DEF_N_REQ     = 2;
  localparam int unsigned DEF_MAX_BURST = 8;
  localparam int unsigned TAG_W         = $clog2(DEF_N_REQ);
  localparam int unsigned CNT_W         = $clog2(DEF_MAX_BURST + 1);

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dram_req_arbiter_if.sv
// dram_req_arbiter_if: requester-side and DRAM-controller-side signals of the arbiter.
//   slave  : arbiter view (requests/controller responses in, commands/read returns out).
//   master : testbench / surrounding-system view.
//   stat_cmds (N_REQ*32) exists only when DRAM_ARB_STATS_EN is defined.
interface dram_req_arbiter_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 144,
  parameter int unsigned BE_W   = 18
);
  logic                    phy_ready;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_rnw;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*BE_W-1:0]   req_wbe;
  logic [N_REQ-1:0]        req_ack;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    dram_cmd_valid;
  logic                    dram_cmd_rnw;
  logic [ADDR_W-1:0]       dram_cmd_addr;
  logic [DATA_W-1:0]       dram_wr_data;
  logic [BE_W-1:0]         dram_wr_be;
  logic                    dram_cmd_ack;
  logic                    dram_rd_valid;
  logic [DATA_W-1:0]       dram_rd_data;
  logic                    busy;
  logic                    rd_orphan;
`ifdef DRAM_ARB_STATS_EN
  logic [N_REQ*32-1:0]     stat_cmds;
`endif

  modport slave (
    input  phy_ready, req_valid, req_rnw, req_addr, req_wdata, req_wbe,
    input  dram_cmd_ack, dram_rd_valid, dram_rd_data,
    output req_ack, rsp_valid, rsp_data,
    output dram_cmd_valid, dram_cmd_rnw, dram_cmd_addr, dram_wr_data, dram_wr_be,
    output busy, rd_orphan
`ifdef DRAM_ARB_STATS_EN
    , output stat_cmds
`endif
  );

  modport master (
    output phy_ready, req_valid, req_rnw, req_addr, req_wdata, req_wbe,
    output dram_cmd_ack, dram_rd_valid, dram_rd_data,
    input  req_ack, rsp_valid, rsp_data,
    input  dram_cmd_valid, dram_cmd_rnw, dram_cmd_addr, dram_wr_data, dram_wr_be,
    input  busy, rd_orphan
`ifdef DRAM_ARB_STATS_EN
    , input stat_cmds
`endif
  );

endinterface

// File: rtl/dram_arb_tag_fifo.sv
// dram_arb_tag_fifo: first-word-fall-through FIFO holding requester tags of outstanding reads.
//   i_clk, i_rst (sync, active-high), i_push/i_din write, i_pop consume head,
//   o_dout = current head, o_full / o_empty status.
//   Push and pop together are allowed at any occupancy (including full); occupancy is unchanged.
module dram_arb_tag_fifo
  import dram_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PTR_W = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // At full with a simultaneous pop, the head is read combinationally before the slot is reused.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{PTR_W{1'b0}}, i_push} - {{PTR_W{1'b0}}, i_pop};
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));

endmodule

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: shares one DDR2 command port between N_REQ requesters.
//   i_dram_clk_div : sole clock.   i_dram_rst_div : synchronous active-high reset.
//   io_bus (dram_req_arbiter_if.slave): requester commands/acks, read returns, DRAM command
//   port, busy and sticky rd_orphan.
//   Traffic is held until phy_ready; round-robin grants of up to MAX_BURST commands; each
//   accepted read records its requester in a tag FIFO so returned data is routed back.
//   Optional: DRAM_ARB_STATS_EN adds stat_cmds, per-requester accepted-command counters.
module dram_req_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 144,
  parameter int unsigned BE_W      = 18,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic            i_dram_clk_div,
  input  logic            i_dram_rst_div,
  dram_req_arbiter_if.slave io_bus
);
  localparam int unsigned IDX_W  = ptr_w(N_REQ);
  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

  dram_arb_state_e   r_state;
  logic [IDX_W-1:0]  r_grant;
  logic [IDX_W-1:0]  r_rr;
  logic [BEAT_W-1:0] r_beat;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_orphan;

  logic              w_in_burst;
  logic              w_g_valid;
  logic              w_g_rnw;
  logic              w_cmd_valid;
  logic              w_accept;
  logic              w_tag_pop;
  logic              w_tag_full;
  logic              w_tag_empty;
  logic [IDX_W-1:0]  w_tag_head;
  logic [IDX_W-1:0]  w_pick;
  logic [IDX_W-1:0]  w_rr_next;
  logic [BEAT_W-1:0] w_beat_next;
  logic [N_REQ-1:0]  w_grant_oh;
  logic [N_REQ-1:0]  w_head_oh;

  assign w_in_burst  = (r_state == StBurst);
  assign w_g_valid   = io_bus.req_valid[r_grant];
  assign w_g_rnw     = io_bus.req_rnw[r_grant];
  assign w_tag_pop   = io_bus.dram_rd_valid & ~w_tag_empty;
  // A read may still go out at full when a tag is popped in the same cycle.
  assign w_cmd_valid = w_in_burst & w_g_valid & io_bus.phy_ready &
                       ~(w_g_rnw & w_tag_full & ~w_tag_pop);
  assign w_accept    = w_cmd_valid & io_bus.dram_cmd_ack;
  assign w_beat_next = r_beat + BEAT_W'(w_accept);
  assign w_rr_next   = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
  assign w_grant_oh  = {{(N_REQ - 1){1'b0}}, 1'b1} << r_grant;
  assign w_head_oh   = {{(N_REQ - 1){1'b0}}, 1'b1} << w_tag_head;

  // Scan downward so the last hit wins: the first valid requester at or above r_rr (mod N_REQ).
  always_comb begin
    w_pick = r_rr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (io_bus.req_valid[(int'(r_rr) + i) % N_REQ]) begin
        w_pick = IDX_W'((int'(r_rr) + i) % N_REQ);
      end
    end
  end

  dram_arb_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk   (i_dram_clk_div),
    .i_rst   (i_dram_rst_div),
    .i_push  (w_accept & w_g_rnw),
    .i_pop   (w_tag_pop),
    .i_din   (r_grant),
    .o_dout  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  always_ff @(posedge i_dram_clk_div) begin
    if (i_dram_rst_div) begin
      r_state     <= StWaitCal;
      r_grant     <= '0;
      r_rr        <= '0;
      r_beat      <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_orphan    <= 1'b0;
    end else begin
      // Read return routing runs regardless of state, so outstanding reads survive a recal.
      r_rsp_valid <= w_tag_pop ? w_head_oh : '0;
      if (w_tag_pop) r_rsp_data <= io_bus.dram_rd_data;
      if (io_bus.dram_rd_valid && w_tag_empty) r_orphan <= 1'b1;

      if (!io_bus.phy_ready) begin
        r_state <= StWaitCal;
        if (w_in_burst) begin
          r_rr   <= w_rr_next;
          r_beat <= '0;
        end
      end else begin
        unique case (r_state)
          StWaitCal: r_state <= StIdle;
          StIdle: begin
            if (|io_bus.req_valid) begin
              r_grant <= w_pick;
              r_state <= StBurst;
            end
          end
          StBurst: begin
            if ((w_beat_next == BEAT_W'(MAX_BURST)) || !w_g_valid) begin
              r_state <= StIdle;
              r_rr    <= w_rr_next;
              r_beat  <= '0;
            end else begin
              r_beat  <= w_beat_next;
            end
          end
          default: r_state <= StWaitCal;
        endcase
      end
    end
  end

  assign io_bus.dram_cmd_valid = w_cmd_valid;
  assign io_bus.dram_cmd_rnw   = w_in_burst & w_g_rnw;
  assign io_bus.dram_cmd_addr  = w_in_burst ? io_bus.req_addr[int'(r_grant)*ADDR_W +: ADDR_W] : '0;
  assign io_bus.dram_wr_data   = w_in_burst ? io_bus.req_wdata[int'(r_grant)*DATA_W +: DATA_W] : '0;
  assign io_bus.dram_wr_be     = w_in_burst ? io_bus.req_wbe[int'(r_grant)*BE_W +: BE_W] : '0;
  assign io_bus.req_ack        = w_accept ? w_grant_oh : '0;
  assign io_bus.rsp_valid      = r_rsp_valid;
  assign io_bus.rsp_data       = r_rsp_data;
  assign io_bus.busy           = w_in_burst | ~w_tag_empty;
  assign io_bus.rd_orphan      = r_orphan;

`ifdef DRAM_ARB_STATS_EN
  logic [31:0] r_stat [N_REQ];

  always_ff @(posedge i_dram_clk_div) begin
    if (i_dram_rst_div) begin
      for (int i = 0; i < N_REQ; i++) r_stat[i] <= '0;
    end else if (w_accept) begin
      r_stat[r_grant] <= r_stat[r_grant] + 32'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign io_bus.stat_cmds[g*32 +: 32] = r_stat[g];
  end
`endif

endmodule
